register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit architectural register file for the single-cycle RV32 core.
- Sits directly downstream of the 5-to-32 write-address decoder (decoder_5_to_32). It consumes the one-hot write enables and stores write-back data.
- Two combinational read ports feed the ALU operand muxes. One synchronous write port is driven by the write-back stage.
- x0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register.
- BYPASS, 0, 1 enables same-cycle write-to-read forwarding; 0 means reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears every register.
- wr_ena  input  1  write enable from write-back stage.
- wr_addr  input  5  destination register index.
- wr_data  input  WIDTH  write-back data.
- rd_addr0  input  5  read port 0 index (rs1).
- rd_addr1  input  5  read port 1 index (rs2).
- rd_data0  output  WIDTH  read port 0 data.
- rd_data1  output  WIDTH  read port 1 data.

Behaviour:
- Reset:
  - rst high asynchronously forces all 32 registers to 0, independent of clk.
  - While rst is high, rd_data0 and rd_data1 read 0 for every address.
  - rst dominates a simultaneous write: the write is dropped.
  - After rst deasserts, the first rising edge with wr_ena performs a normal write.
- Write decode:
  - wr_addr and wr_ena drive one decoder_5_to_32 instance (ena=wr_ena, in=wr_addr).
  - Decoder output bit i is the load enable of register i.
  - Output bit 0 is left unconnected, so x0 never loads.
- Write timing:
  - On the rising clk edge, register[wr_addr] <= wr_data when wr_ena=1 and wr_addr!=0.
  - Write latency is 1 cycle: the new value is visible on read ports the cycle after the edge.
  - wr_ena=0 leaves all registers unchanged, whatever wr_addr and wr_data are.
- Reads:
  - Purely combinational, 0 latency: rd_dataN = register[rd_addrN].
  - Address 0 always returns 0.
  - Both ports may read the same address; they return identical data.
- Bypass (BYPASS=1 only):
  - If wr_ena=1, wr_addr!=0 and rd_addrN==wr_addr, then rd_dataN = wr_data in the same cycle, before the edge.
  - Applies to each port independently.
  - Never applies to address 0.
  - Never applies while rst is high.
- Bypass off (BYPASS=0): reads during a same-address write return the old value until the edge.
- Storage: one flip-flop register per index 1..31.
  - Each register has an asynchronous clear and a synchronous enable.
  - No storage for index 0.
- X handling: unknown wr_addr with wr_ena=0 must not corrupt any register.

Decomposition:
- Shared package rv32_pkg:
  - REG_COUNT=32.
  - REG_ADDR_W=5.
  - XLEN=32.
  - typedef reg_addr_t (logic [4:0]).
  - typedef word_t (logic [31:0]).
  - constant REG_ZERO=5'd0.
- One natural sub-module: register_en (WIDTH-bit flop with async active-high clear and load enable), instantiated 31 times via generate loop.
- Read muxing: an always_comb index per port inside register_file; no separate module.

Test Plan:
- Reset clear: write 32'hDEADBEEF to x5, pulse rst mid-cycle (between edges) -> rd_data0 for x5 reads 0 immediately, without waiting for a clk edge. All 32 addresses read 0.
- Basic write/read: write x1=32'h0000_0011, x31=32'hFFFF_FFFF on consecutive edges; set rd_addr0=1, rd_addr1=31 -> rd_data0=32'h11, rd_data1=32'hFFFFFFFF. All other registers remain 0.
- x0 immutability: wr_ena=1, wr_addr=0, wr_data=32'hCAFEF00D, clock -> rd_data0 with rd_addr0=0 reads 0. With BYPASS=1, also reads 0 in the write cycle.
- Write enable gating: write x7=32'h1234 then hold wr_ena=0, wr_addr=7, wr_data=32'h5678 for 3 edges -> x7 stays 32'h1234.
- Bypass: x9=32'hAAAA stored. Next cycle wr_ena=1, wr_addr=9, wr_data=32'hBBBB, rd_addr0=rd_addr1=9:
  - BYPASS=1 -> both ports read 32'hBBBB before the edge.
  - BYPASS=0 -> both ports read 32'hAAAA before the edge and 32'hBBBB after.
- Reset vs write race: rst asserted across an edge with wr_ena=1, wr_addr=3, wr_data=32'h77 -> x3 reads 0 after rst deasserts.

Source files
------------

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared constants and types for the RV32 core: register-file geometry,
// the architectural word type and the index of the hardwired zero register.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/decoder_5_to_32.sv
// ---------------------------------------------------------------------------
// decoder_5_to_32
// One-hot decoder for the register-file write address. With ena low every
// output is 0, so an unknown address cannot raise a load enable.
// Ports:
//   ena  in   1   decode enable
//   in   in   5   binary index
//   out  out  32  one-hot result (all zero when ena=0)
// ---------------------------------------------------------------------------
module decoder_5_to_32
  import rv32_pkg::*;
(
  input  logic                 ena,
  input  logic [REG_ADDR_W-1:0] in,
  output logic [REG_COUNT-1:0]  out
);

  always_comb begin
    out = '0;
    if (ena) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/register_en.sv
// ---------------------------------------------------------------------------
// register_en
// WIDTH-bit storage flop with asynchronous active-high clear and a
// synchronous load enable.
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous active-high clear
//   en   in   1      load enable
//   d    in   WIDTH  load data
//   q    out  WIDTH  stored value
// ---------------------------------------------------------------------------
module register_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32 x WIDTH architectural register file: one synchronous write port, two
// combinational read ports, x0 hardwired to zero. Optional same-cycle
// write-to-read forwarding when BYPASS=1.
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset, clears all registers
//   wr_ena    in   1      write enable
//   wr_addr   in   5      destination index
//   wr_data   in   WIDTH  write data
//   rd_addr0  in   5      read port 0 index (rs1)
//   rd_addr1  in   5      read port 1 index (rs2)
//   rd_data0  out  WIDTH  read port 0 data
//   rd_data1  out  WIDTH  read port 1 data
// ---------------------------------------------------------------------------
module register_file
  import rv32_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr0,
  input  logic [4:0]       rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1
);

  logic [REG_COUNT-1:0] w_load;
  logic [WIDTH-1:0]     w_q [REG_COUNT];
  logic                 w_byp0;
  logic                 w_byp1;
  logic [WIDTH-1:0]     w_rd0;
  logic [WIDTH-1:0]     w_rd1;

  decoder_5_to_32 u_wr_dec (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (w_load)
  );

  // x0 has no storage; its load enable (w_load[0]) is deliberately ignored.
  assign w_q[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
      register_en #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_load[gi]),
        .d   (wr_data),
        .q   (w_q[gi])
      );
    end
  endgenerate

  // Forwarding is suppressed during reset so reads stay at 0 even while a
  // write is being presented.
  assign w_byp0 = (BYPASS != 0) && !rst && wr_ena &&
                  (wr_addr != REG_ZERO) && (rd_addr0 == wr_addr);
  assign w_byp1 = (BYPASS != 0) && !rst && wr_ena &&
                  (wr_addr != REG_ZERO) && (rd_addr1 == wr_addr);

  always_comb begin
    w_rd0 = w_q[rd_addr0];
    if (w_byp0) begin
      w_rd0 = wr_data;
    end
  end

  always_comb begin
    w_rd1 = w_q[rd_addr1];
    if (w_byp1) begin
      w_rd1 = wr_data;
    end
  end

  assign rd_data0 = w_rd0;
  assign rd_data1 = w_rd1;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] nb_rd0, nb_rd1;   // BYPASS=0 instance
  logic [31:0] by_rd0, by_rd1;   // BYPASS=1 instance

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.WIDTH(32), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(nb_rd0), .rd_data1(nb_rd1)
  );

  register_file #(.WIDTH(32), .BYPASS(1)) u_dut_by (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(by_rd0), .rd_data1(by_rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register contents.
  logic [31:0] mdl [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
    end else if (wr_ena === 1'b1 && wr_addr != 5'd0) begin
      mdl[wr_addr] <= wr_data;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] nb0, nb1, by0, by1;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst) return '0;
    if (a == 5'd0) return '0;
    if (byp && wr_ena === 1'b1 && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Push the expectation for the currently driven inputs, let the
  // combinational read settle, then pop and compare all four read ports.
  task automatic sample(input string tag);
    exp_t e;
    e.tag = tag;
    e.nb0 = exp_rd(rd_addr0, 1'b0);
    e.nb1 = exp_rd(rd_addr1, 1'b0);
    e.by0 = exp_rd(rd_addr0, 1'b1);
    e.by1 = exp_rd(rd_addr1, 1'b1);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.tag, ".nb0"}, nb_rd0, e.nb0);
    check({e.tag, ".nb1"}, nb_rd1, e.nb1);
    check({e.tag, ".by0"}, by_rd0, e.by0);
    check({e.tag, ".by1"}, by_rd1, e.by1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_ena  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rd_addr0 = a0;
    rd_addr1 = a1;
    sample(tag);
  endtask

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    repeat (2) @(posedge clk);

    // Reset state: everything reads 0.
    for (int i = 0; i < 32; i += 2) rd($sformatf("rst_init%0d", i), 5'(i), 5'(i + 1));
    @(negedge clk); rst = 1'b0;

    // Reset clears asynchronously, mid-cycle.
    wr(5'd5, 32'hDEADBEEF);
    rd("x5_written", 5'd5, 5'd5);
    check("x5_const", nb_rd0, 32'hDEADBEEF);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_clr_nb", nb_rd0, 32'h0);
    check("async_clr_by", by_rd0, 32'h0);
    for (int i = 0; i < 32; i += 2) rd($sformatf("rst_all%0d", i), 5'(i), 5'(i + 1));
    @(negedge clk); rst = 1'b0;

    // Basic write/read.
    wr(5'd1, 32'h0000_0011);
    wr(5'd31, 32'hFFFF_FFFF);
    rd("basic", 5'd1, 5'd31);
    check("basic_x1", nb_rd0, 32'h11);
    check("basic_x31", nb_rd1, 32'hFFFF_FFFF);
    for (int i = 2; i < 31; i += 2) rd($sformatf("others%0d", i), 5'(i), 5'(i + 1));

    // x0 immutability, including the write cycle itself.
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFEF00D;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    sample("x0_inwrite");
    check("x0_by_const", by_rd0, 32'h0);
    @(posedge clk); #1; wr_ena = 1'b0;
    rd("x0_after", 5'd0, 5'd0);

    // Write enable gating.
    wr(5'd7, 32'h1234);
    @(negedge clk);
    wr_ena = 1'b0; wr_addr = 5'd7; wr_data = 32'h5678;
    repeat (3) @(posedge clk);
    rd("gate_x7", 5'd7, 5'd7);
    check("gate_x7_const", nb_rd0, 32'h1234);

    // Unknown address with wr_ena low corrupts nothing.
    @(negedge clk);
    wr_ena = 1'b0; wr_addr = 5'bx; wr_data = 32'hBAD0BAD0;
    repeat (2) @(posedge clk);
    wr_addr = 5'd0;
    rd("xaddr_a", 5'd1, 5'd7);
    rd("xaddr_b", 5'd31, 5'd5);

    // Bypass vs no bypass on a same-address write.
    wr(5'd9, 32'hAAAA);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'hBBBB;
    rd_addr0 = 5'd9; rd_addr1 = 5'd9;
    sample("byp_pre");
    check("byp_pre_nb_const", nb_rd1, 32'hAAAA);
    check("byp_pre_by_const", by_rd1, 32'hBBBB);
    @(posedge clk); #1; wr_ena = 1'b0;
    sample("byp_post");
    check("byp_post_nb_const", nb_rd0, 32'hBBBB);

    // Bypass on one port only.
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd12; wr_data = 32'h0F0F_0F0F;
    rd_addr0 = 5'd12; rd_addr1 = 5'd9;
    sample("byp_port0");
    @(posedge clk); #1; wr_ena = 1'b0;

    // Reset dominates a write across an edge; no forwarding during reset.
    @(negedge clk);
    rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    rd_addr0 = 5'd3; rd_addr1 = 5'd3;
    sample("race_inrst");
    @(posedge clk); #1;
    @(negedge clk);
    wr_ena = 1'b0; rst = 1'b0;
    rd("race_after", 5'd3, 5'd9);
    check("race_x3_const", nb_rd0, 32'h0);

    // First write after reset is a normal write.
    wr(5'd3, 32'h77);
    rd("post_rst_wr", 5'd3, 5'd3);
    check("post_rst_const", by_rd1, 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
